prbs23_pkt_gen: RTL and testbench
=================================

Name: prbs23_pkt_gen

Overview:
- Transmit-side test-traffic source for the byte-stream link.
- Emits framed AXI-Stream packets whose payload is a continuous PRBS23 byte sequence, the generator counterpart of the receive-side prbs23 checker and error counter.
- Sits ahead of the TX FEC/CRC chain on the high-rate clock.
- Supports programmable packet length, inter-packet gap, and single-bit error injection for BER bench tests.

Parameters:
- pLEN_W, 12, width of packet-length input (bytes).
- pGAP_W, 8, width of inter-packet gap input (clock cycles).
- pMSB_FIRST, 0, 1/0: first generated PRBS bit goes to tdata MSB/LSB.
- pCNT_W, 16, width of packet and injection counters.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  run request, level-sensitive.
- pkt_len  in  pLEN_W  payload bytes per packet; latched at packet start.
- gap_len  in  pGAP_W  idle cycles between packets; latched at packet start.
- err_inj  in  1  one-cycle pulse requesting a single bit flip.
- m_axis_tdata  out  8  payload byte.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tlast  out  1  last byte of packet.
- m_axis_tuser  out  1  first byte of packet (SOP).
- m_axis_tready  in  1  downstream ready.
- busy  out  1  state != IDLE.
- pkt_cnt  out  pCNT_W  completed packets, wraps.
- inj_cnt  out  pCNT_W  injected errors, wraps.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0; state IDLE.
  - PRBS register = 23'h7FFFFF; pending-inject flag cleared.
  - Reset mid-packet aborts immediately; no tlast is emitted.
- PRBS: polynomial x^23+x^18+1, 23-bit state s.
  - Per bit: b = s[22]^s[17]; s <= {s[21:0], b}.
  - Each byte uses 8 bits, advancing s by 8 in one cycle.
  - With pMSB_FIRST=0, bit k of the byte = k-th generated bit.
  - The sequence runs continuously across packets and gaps. It never reseeds except on reset.
- Output register: a new beat is loaded when (!tvalid || tready) and the FSM requires a beat.
  - While tvalid=1 and tready=0, tdata, tlast and tuser stay frozen.
  - PRBS state advances only on load.
- FSM:
  - IDLE: if enable=1 and pkt_len!=0, latch len/gap, load the first beat (tuser=1), go to PAYLOAD. tvalid is 1 after the same edge. If pkt_len=0, stay in IDLE.
  - PAYLOAD: byte counter counts accepted beats.
    - Load beat i with tlast=1 when i = len-1. For len=1 the single beat has tuser=tlast=1.
    - On acceptance of the tlast beat: pkt_cnt+1. Go to GAP if gap!=0, else directly back to IDLE evaluation on the same edge, so the next SOP can appear in the next cycle with no bubble.
  - GAP: tvalid=0; count gap cycles, then go to IDLE.
  - enable falling mid-packet: the current packet completes normally, then the block stays in IDLE.
- Error injection:
  - An err_inj pulse sets the pending flag. Pulses while already pending are merged.
  - At the next beat load, tdata[0] of that beat is inverted, the flag clears and inj_cnt+1.
  - The PRBS state is not affected by the flip, so the checker sees exactly one bit error.
  - A pulse coincident with a load applies to that beat.
- Counters wrap at 2^pCNT_W with no saturation.
- busy = (state != IDLE).

Test Plan:
- Seed check: rst release, enable=1, pkt_len=4, gap_len=0, tready=1 → tdata 0x00, 0x00, 0x7C, next byte per model. tuser on beat 0, tlast on beat 3. pkt_cnt=1 after beat 3.
- Backpressure: tready toggled pseudo-randomly, len=16 → 16 beats with no duplication or loss; tdata/tlast/tuser frozen while tready=0. Byte stream equals the reference PRBS23 model.
- Gap/continuity: len=3, gap=5 → exactly 5 tvalid=0 cycles between tlast and the next tuser. The PRBS continues across packets; gap=0 gives back-to-back packets. Loop into the checker for 10^5 bytes → zero errors.
- Injection: two err_inj pulses 3 cycles apart during stalled tready → inj_cnt=2. Checker error count=2; each corrupted byte differs from the model only in bit 0.
- Boundaries:
  - len=1 → tuser=tlast=1 on the same beat.
  - pkt_len=0 → no tvalid.
  - enable dropped on beat 2 of 8 → all 8 beats sent, then IDLE with busy=0.
  - pkt_cnt rolls from 0xFFFF to 0.
- Reset mid-packet: rst=0 on beat 5 of 10 → all outputs 0 immediately. After release with enable=1, the stream restarts at 0x00, 0x00, 0x7C with tuser=1.

Source files
------------

// File: rtl/prbs23_pkt_gen.sv
// PRBS23 (x^23+x^18+1) packet generator: framed AXI-Stream payload with programmable
// length and inter-packet gap, plus single-bit error injection on bit 0 of a beat.
module prbs23_pkt_gen #(
  parameter int pLEN_W     = 12,
  parameter int pGAP_W     = 8,
  parameter bit pMSB_FIRST = 1'b0,
  parameter int pCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [pLEN_W-1:0] pkt_len,
  input  logic [pGAP_W-1:0] gap_len,
  input  logic              err_inj,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic [pCNT_W-1:0] pkt_cnt,
  output logic [pCNT_W-1:0] inj_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_GAP} state_t;

  localparam logic [pLEN_W-1:0] LEN_ONE = pLEN_W'(1);
  localparam logic [pGAP_W-1:0] GAP_ONE = pGAP_W'(1);
  localparam logic [pCNT_W-1:0] CNT_ONE = pCNT_W'(1);

  state_t            state_reg;
  logic [22:0]       prbs_reg;
  logic [22:0]       prbs_next;
  logic [7:0]        byte_next;
  logic [pLEN_W-1:0] len_reg;
  logic [pLEN_W-1:0] beat_idx_reg;
  logic [pGAP_W-1:0] gap_reg;
  logic [pGAP_W-1:0] gap_cnt_reg;
  logic              inj_pend_reg;
  logic [7:0]        tdata_reg;
  logic              tvalid_reg;
  logic              tlast_reg;
  logic              tuser_reg;
  logic [pCNT_W-1:0] pkt_cnt_reg;
  logic [pCNT_W-1:0] inj_cnt_reg;

  logic can_load;
  logic start_ok;
  logic eop_accept;
  logic restart;
  logic load_mid;
  logic load;
  logic inj_now;

  // Advance the LFSR eight steps; the first generated bit lands at bit 0 (or bit 7).
  function automatic logic [30:0] prbs_step8(input logic [22:0] s);
    logic [22:0] st;
    logic [7:0]  by;
    logic        fb;
    st = s;
    by = '0;
    for (int k = 0; k < 8; k++) begin
      fb = st[22] ^ st[17];
      by = pMSB_FIRST ? {by[6:0], fb} : {fb, by[7:1]};
      st = {st[21:0], fb};
    end
    return {st, by};
  endfunction

  assign {prbs_next, byte_next} = prbs_step8(prbs_reg);

  assign can_load   = !tvalid_reg || m_axis_tready;
  assign start_ok   = enable && (pkt_len != '0);
  assign eop_accept = (state_reg == ST_PAYLOAD) && tvalid_reg && tlast_reg && m_axis_tready;
  // A new packet may start from IDLE, straight off an accepted tlast when there is
  // no gap, or on the final gap cycle, so neither case inserts an extra bubble.
  assign restart    = start_ok && ((state_reg == ST_IDLE) ||
                                   (eop_accept && (gap_reg == '0)) ||
                                   ((state_reg == ST_GAP) && (gap_cnt_reg == '0)));
  assign load_mid   = (state_reg == ST_PAYLOAD) && can_load && !tlast_reg;
  assign load       = restart || load_mid;
  assign inj_now    = inj_pend_reg || err_inj;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      prbs_reg     <= 23'h7FFFFF;
      len_reg      <= '0;
      beat_idx_reg <= '0;
      gap_reg      <= '0;
      gap_cnt_reg  <= '0;
      inj_pend_reg <= 1'b0;
      tdata_reg    <= '0;
      tvalid_reg   <= 1'b0;
      tlast_reg    <= 1'b0;
      tuser_reg    <= 1'b0;
      pkt_cnt_reg  <= '0;
      inj_cnt_reg  <= '0;
    end else begin
      // The flip touches only the output byte, never the LFSR state.
      if (load) begin
        prbs_reg     <= prbs_next;
        tdata_reg    <= byte_next ^ {7'b0, inj_now};
        tvalid_reg   <= 1'b1;
        inj_pend_reg <= 1'b0;
        if (inj_now) begin
          inj_cnt_reg <= inj_cnt_reg + CNT_ONE;
        end
      end else if (err_inj) begin
        inj_pend_reg <= 1'b1;
      end

      if (eop_accept) begin
        pkt_cnt_reg <= pkt_cnt_reg + CNT_ONE;
      end

      if (restart) begin
        state_reg    <= ST_PAYLOAD;
        len_reg      <= pkt_len;
        gap_reg      <= gap_len;
        beat_idx_reg <= LEN_ONE;
        tuser_reg    <= 1'b1;
        tlast_reg    <= (pkt_len == LEN_ONE);
      end else if (load_mid) begin
        tuser_reg    <= 1'b0;
        tlast_reg    <= (beat_idx_reg == (len_reg - LEN_ONE));
        beat_idx_reg <= beat_idx_reg + LEN_ONE;
      end else if (eop_accept) begin
        tvalid_reg <= 1'b0;
        tuser_reg  <= 1'b0;
        tlast_reg  <= 1'b0;
        if (gap_reg != '0) begin
          state_reg   <= ST_GAP;
          gap_cnt_reg <= gap_reg - GAP_ONE;
        end else begin
          state_reg <= ST_IDLE;
        end
      end else if (state_reg == ST_GAP) begin
        if (gap_cnt_reg == '0) begin
          state_reg <= ST_IDLE;
        end else begin
          gap_cnt_reg <= gap_cnt_reg - GAP_ONE;
        end
      end
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign m_axis_tuser  = tuser_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign pkt_cnt       = pkt_cnt_reg;
  assign inj_cnt       = inj_cnt_reg;

endmodule

// File: tb/tb_prbs23_pkt_gen.sv
// Bench for prbs23_pkt_gen: table of packet shapes plus hand sequences, checked
// against a bit-recurrence PRBS23 model and a stream monitor.
module tb_prbs23_pkt_gen;

  localparam int LEN_W = 12;
  localparam int GAP_W = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [LEN_W-1:0] pkt_len = '0;
  logic [GAP_W-1:0] gap_len = '0;
  logic             err_inj = 1'b0;
  logic             m_axis_tready = 1'b0;
  logic [7:0]       m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tuser;
  logic             busy;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] inj_cnt;

  int checks = 0;
  int failures = 0;

  prbs23_pkt_gen #(
    .pLEN_W(LEN_W), .pGAP_W(GAP_W), .pMSB_FIRST(1'b0), .pCNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pkt_len(pkt_len), .gap_len(gap_len),
    .err_inj(err_inj), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tready(m_axis_tready), .busy(busy), .pkt_cnt(pkt_cnt), .inj_cnt(inj_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: generated bit g[n] = g[n-23] ^ g[n-18], history seeded with 23 ones.
  bit gbits[$];
  function automatic void model_reset();
    gbits.delete();
    repeat (23) gbits.push_back(1'b1);
  endfunction
  function automatic logic [7:0] model_byte();
    logic [7:0] b;
    bit g;
    for (int k = 0; k < 8; k++) begin
      g = gbits[0] ^ gbits[5];
      gbits.push_back(g);
      void'(gbits.pop_front());
      b[k] = g;
    end
    return b;
  endfunction

  // Monitor state (written only by the monitor process)
  int acc_cnt = 0;
  int corrupt_cnt = 0;
  int valid_cycles = 0;
  int beat_idx = 0;
  int gap_cycles = 0;
  bit gap_counting = 0;
  int gap_q[$];
  int corrupt_idx[$];
  logic [7:0] cap[$];
  int exp_len = 1;

  initial begin : monitor
    logic [7:0] exp_b;
    logic [7:0] diff;
    logic       prev_v;
    logic       prev_r;
    logic       prev_l;
    logic       prev_u;
    logic [7:0] prev_d;
    prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_u = 1'b0; prev_d = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        model_reset();
        acc_cnt = 0; corrupt_cnt = 0; beat_idx = 0; gap_counting = 0; prev_v = 1'b0;
        cap.delete(); corrupt_idx.delete(); gap_q.delete();
      end else begin
        if (m_axis_tvalid) valid_cycles++;
        if (prev_v && !prev_r)
          check("frozen_beat", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser},
                {1'b1, prev_d, prev_l, prev_u});
        if (gap_counting) begin
          if (m_axis_tvalid) begin
            gap_q.push_back(gap_cycles);
            gap_counting = 0;
          end else if (!busy) begin
            gap_counting = 0;
          end else begin
            gap_cycles++;
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          exp_b = model_byte();
          diff = m_axis_tdata ^ exp_b;
          checks++;
          if (diff == 8'h01) begin
            corrupt_cnt++;
            corrupt_idx.push_back(acc_cnt);
          end else if (diff != 8'h00) begin
            failures++;
            $display("FAIL beat_data[%0d]: got 0x%02h expected 0x%02h", acc_cnt, m_axis_tdata, exp_b);
          end
          check("beat_tuser", m_axis_tuser, (beat_idx == 0));
          check("beat_tlast", m_axis_tlast, (beat_idx == exp_len - 1));
          cap.push_back(m_axis_tdata);
          acc_cnt++;
          if (m_axis_tlast) begin
            beat_idx = 0; gap_counting = 1; gap_cycles = 0;
          end else begin
            beat_idx++;
          end
        end
        prev_v = m_axis_tvalid; prev_r = m_axis_tready; prev_l = m_axis_tlast;
        prev_u = m_axis_tuser;  prev_d = m_axis_tdata;
      end
    end
  end

  typedef struct {
    int len;
    int gap;
    bit rand_ready;
    int npkt;
    int exp_beats;
    int exp_gap;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit rand_ready);
    int budget;
    budget = 0;
    while ((busy || m_axis_tvalid) && budget < 5000) begin
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      budget++;
    end
    check("drain_timeout", (budget < 5000), 1);
    m_axis_tready = 1'b1;
    step(); step();
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int acc0, cor0, gq0, sop, budget;
    logic [CNT_W-1:0] pc0;
    logic [CNT_W-1:0] pc_exp;
    acc0 = acc_cnt; cor0 = corrupt_cnt; gq0 = gap_q.size(); pc0 = pkt_cnt;
    exp_len = v.len;
    pkt_len = LEN_W'(v.len);
    gap_len = GAP_W'(v.gap);
    enable = 1'b1;
    sop = 0; budget = 0;
    while (sop < v.npkt && budget < 20000) begin
      m_axis_tready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axis_tvalid && m_axis_tready && m_axis_tuser) sop++;
      if (sop == v.npkt) enable = 1'b0;
      step();
      budget++;
    end
    enable = 1'b0;
    check("vec_timeout", (budget < 20000), 1);
    drain(v.rand_ready);
    pc_exp = pc0 + CNT_W'(v.npkt);
    check("vec_pkt_cnt", pkt_cnt, pc_exp);
    check("vec_beats", acc_cnt - acc0, v.exp_beats);
    check("vec_no_corrupt", corrupt_cnt - cor0, 0);
    check("vec_gap_count", gap_q.size() - gq0, v.npkt - 1);
    for (int i = gq0; i < gap_q.size(); i++) check("vec_gap_len", gap_q[i], v.exp_gap);
    check("vec_idle_busy", busy, 0);
    $display("vec %0d len=%0d gap=%0d rand_ready=%0d npkt=%0d beats=%0d pkt_cnt=%0d",
             id, v.len, v.gap, v.rand_ready, v.npkt, acc_cnt - acc0, pkt_cnt);
  endtask

  vec_t vecs[10];
  vec_t roll;

  initial begin
    int n, vc0, acc0, cor0, inj0, budget, exp_idx;
    logic [7:0] seed_bytes [4];
    seed_bytes = '{8'h00, 8'h00, 8'h7C, 8'h00};

    vecs[0] = '{4, 0, 1'b0, 1, 4, 0};
    vecs[1] = '{16, 0, 1'b1, 3, 48, 0};
    vecs[2] = '{3, 5, 1'b0, 4, 12, 5};
    vecs[3] = '{3, 0, 1'b0, 4, 12, 0};
    vecs[4] = '{1, 0, 1'b0, 5, 5, 0};
    vecs[5] = '{1, 2, 1'b1, 4, 4, 2};
    vecs[6] = '{7, 1, 1'b1, 3, 21, 1};
    for (int i = 7; i < 10; i++) begin
      n = $urandom_range(2, 40);
      vecs[i].len = n;
      vecs[i].gap = $urandom_range(0, 7);
      vecs[i].rand_ready = 1'b1;
      vecs[i].npkt = 3;
      vecs[i].exp_beats = 3 * n;
      vecs[i].exp_gap = vecs[i].gap;
    end

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("reset_outputs", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, pkt_cnt, inj_cnt}, 0);
    step(); step();
    rst = 1'b1;
    m_axis_tready = 1'b1;

    // Seed: first bytes after reset
    run_vec(0, vecs[0]);
    check("seed_len", cap.size(), 4);
    for (int i = 0; i < 4; i++) check("seed_byte", cap[i], seed_bytes[i]);

    for (int i = 1; i < 10; i++) run_vec(i, vecs[i]);

    // pkt_len = 0 never starts a packet
    vc0 = valid_cycles;
    pkt_len = '0; enable = 1'b1;
    repeat (20) step();
    check("len0_no_valid", valid_cycles - vc0, 0);
    check("len0_busy", busy, 0);
    enable = 1'b0;
    $display("len0 valid_cycles=%0d", valid_cycles - vc0);

    // Enable dropped during beat 2 of 8: packet still completes
    acc0 = acc_cnt; exp_len = 8; pkt_len = LEN_W'(8); gap_len = '0; enable = 1'b1;
    budget = 0;
    while (acc_cnt - acc0 < 1 && budget < 100) begin step(); budget++; end
    enable = 1'b0;
    drain(1'b0);
    check("endrop_beats", acc_cnt - acc0, 8);
    check("endrop_busy", busy, 0);
    $display("enable_drop beats=%0d busy=%0d", acc_cnt - acc0, busy);

    // Error injection: two pulses around stalls, a merged pair, and a coincident pulse
    exp_len = 16; pkt_len = LEN_W'(16); gap_len = '0; enable = 1'b1;
    cor0 = corrupt_cnt; inj0 = inj_cnt;
    budget = 0;
    while (!m_axis_tvalid && budget < 100) begin step(); budget++; end
    check("inj_start_timeout", m_axis_tvalid, 1);
    m_axis_tready = 1'b0; err_inj = 1'b1; step();
    err_inj = 1'b0; m_axis_tready = 1'b1; step();
    m_axis_tready = 1'b0; step();
    err_inj = 1'b1; step();
    err_inj = 1'b0; step();
    m_axis_tready = 1'b1; step();
    check("inj_cnt_two", inj_cnt, CNT_W'(inj0 + 2));
    m_axis_tready = 1'b0; err_inj = 1'b1; step();
    err_inj = 1'b0; step();
    err_inj = 1'b1; step();
    err_inj = 1'b0; m_axis_tready = 1'b1; step();
    check("inj_cnt_merged", inj_cnt, CNT_W'(inj0 + 3));
    exp_idx = acc_cnt + 1;
    err_inj = 1'b1; step();
    err_inj = 1'b0;
    check("inj_cnt_coincident", inj_cnt, CNT_W'(inj0 + 4));
    repeat (5) step();
    enable = 1'b0;
    drain(1'b0);
    check("inj_corrupt_count", corrupt_cnt - cor0, 4);
    check("inj_coincident_beat", (corrupt_idx.size() > 0) ? corrupt_idx[$] : -1, exp_idx);
    $display("inject inj_cnt=%0d corrupted=%0d", inj_cnt, corrupt_cnt - cor0);

    // Reset in the middle of a packet
    acc0 = acc_cnt; exp_len = 10; pkt_len = LEN_W'(10); enable = 1'b1;
    budget = 0;
    while (acc_cnt - acc0 < 4 && budget < 100) begin step(); budget++; end
    rst = 1'b0;
    #1;
    check("midrst_outputs", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, pkt_cnt, inj_cnt}, 0);
    step(); step();
    rst = 1'b1;
    budget = 0;
    while (!m_axis_tvalid && budget < 100) begin step(); budget++; end
    check("midrst_sop_tuser", m_axis_tuser, 1);
    check("midrst_sop_data", m_axis_tdata, 8'h00);
    budget = 0;
    while (cap.size() < 3 && budget < 100) begin step(); budget++; end
    enable = 1'b0;
    check("midrst_len", (cap.size() >= 3), 1);
    for (int i = 0; i < 3; i++) check("midrst_byte", cap[i], seed_bytes[i]);
    drain(1'b0);
    $display("midreset restart bytes=%02h %02h %02h", cap[0], cap[1], cap[2]);

    // Packet counter wrap from all-ones back to zero
    rst = 1'b0; step(); step(); rst = 1'b1;
    roll = '{1, 0, 1'b0, 256, 256, 0};
    run_vec(10, roll);
    check("pkt_cnt_wrap", pkt_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
